// File: rtl/prach_cp_strip_framer.sv
// PRACH cyclic-prefix stripper: drops cp_len samples, then forwards fft_len samples
// per symbol for num_sym symbols, framed with sop/eop/sym_idx for the FFT sequencer.
module prach_cp_strip_framer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int SYM_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_WIDTH-1:0]  cp_len,
   input  logic [CNT_WIDTH-1:0]  fft_len,
   input  logic [SYM_WIDTH-1:0]  num_sym,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [SYM_WIDTH-1:0]  sym_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CP_SKIP = 2'd1,
      PASS    = 2'd2
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH-1:0]  cp_r;
   logic [CNT_WIDTH-1:0]  fft_r;
   logic [SYM_WIDTH-1:0]  ns_r;
   logic [SYM_WIDTH-1:0]  sym_r;

   logic                  cfg_ok;
   logic                  cp_last;
   logic                  fft_last;
   logic                  sym_last;

   assign cfg_ok   = (fft_len != '0) && (num_sym != '0);
   assign cp_last  = (cnt == (cp_r - CNT_WIDTH'(1)));
   assign fft_last = (cnt == (fft_r - CNT_WIDTH'(1)));
   assign sym_last = (sym_r == (ns_r - SYM_WIDTH'(1)));

   // Pulse outputs clear on every enabled edge and hold while clk_en is low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         cp_r      <= '0;
         fft_r     <= '0;
         ns_r      <= '0;
         sym_r     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         sym_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else if (clk_en) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            sym_r   <= '0;
            sym_idx <= '0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (cfg_ok) begin
                        cp_r    <= cp_len;
                        fft_r   <= fft_len;
                        ns_r    <= num_sym;
                        cnt     <= '0;
                        sym_r   <= '0;
                        sym_idx <= '0;
                        busy    <= 1'b1;
                        state   <= (cp_len == '0) ? PASS : CP_SKIP;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               CP_SKIP: begin
                  if (start) begin
                     err <= 1'b1;
                  end
                  if (in_valid) begin
                     if (cp_last) begin
                        cnt   <= '0;
                        state <= PASS;
                     end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                     end
                  end
               end
               PASS: begin
                  if (start) begin
                     err <= 1'b1;
                  end
                  if (in_valid) begin
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                     out_sop   <= (cnt == '0);
                     out_eop   <= fft_last;
                     sym_idx   <= sym_r;
                     if (fft_last) begin
                        cnt <= '0;
                        // Last symbol returns to IDLE so a start in the done cycle is taken.
                        if (sym_last) begin
                           sym_r <= '0;
                           done  <= 1'b1;
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           sym_r <= sym_r + SYM_WIDTH'(1);
                           state <= (cp_r == '0) ? PASS : CP_SKIP;
                        end
                     end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/prach_cp_strip_framer.md
# prach_cp_strip_framer

Streaming PRACH front-end stage that sits directly upstream of the FFT counter/sequencer. After a start pulse it discards the cyclic prefix of each PRACH symbol and forwards exactly `fft_len` samples per symbol. The output is framed with start-of-packet/end-of-packet markers and a symbol index, and the sequence repeats for `num_sym` symbols, giving the FFT stage a clean, gap-tolerant sample stream.

## Interface
Parameters:
- `DATA_WIDTH`, 32: packed IQ sample width (I in upper half).
- `CNT_WIDTH`, 16: width of the length fields and the internal sample counter.
- `SYM_WIDTH`, 4: width of the symbol count and symbol index.

Ports:
- `clk`, in, 1: clock. All logic runs on the rising edge.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `clk_en`, in, 1: global clock enable. No register changes while it is 0.
- `start`, in, 1: single-cycle request to begin a PRACH occasion.
- `abort`, in, 1: terminate the current occasion.
- `cp_len`, in, CNT_WIDTH: CP samples to drop per symbol. 0 is legal.
- `fft_len`, in, CNT_WIDTH: samples to forward per symbol. Must be non-zero.
- `num_sym`, in, SYM_WIDTH: symbols per occasion. Must be non-zero.
- `in_valid`, in, 1: input sample strobe.
- `in_data`, in, DATA_WIDTH: input sample.
- `out_valid`, out, 1: forwarded sample strobe.
- `out_data`, out, DATA_WIDTH: forwarded sample.
- `out_sop`, out, 1: first sample of a symbol.
- `out_eop`, out, 1: last sample of a symbol.
- `sym_idx`, out, SYM_WIDTH: symbol index of the current output sample.
- `busy`, out, 1: occasion in progress.
- `done`, out, 1: single pulse marking completion of the occasion.
- `err`, out, 1: single pulse on a rejected `start`.

## Operation
- An input sample is *accepted* when `in_valid` and `clk_en` are both 1. Only accepted samples advance the counter.
- `start` is sampled only in IDLE with `clk_en`=1.
  - `cp_len`, `fft_len` and `num_sym` are latched at that point. Later changes to these inputs are ignored until the next `start`.
  - If `fft_len`=0 or `num_sym`=0, `err` pulses for one cycle and the block stays in IDLE.
  - A `start` received while not in IDLE is ignored and pulses `err`. The running occasion is undisturbed.
- State machine (IDLE, CP_SKIP, PASS):
  - IDLE → CP_SKIP on a valid `start` with latched `cp_len`≠0. IDLE → PASS if `cp_len`=0. The counter and `sym_idx` are cleared on this transition.
  - CP_SKIP: accepted samples are dropped. The counter counts 0..`cp_len`-1. The sample accepted at `cp_len`-1 moves to PASS with the counter cleared.
  - PASS: each accepted sample is forwarded. The counter counts 0..`fft_len`-1.
    - On the sample at `fft_len`-1, if `sym_idx`=`num_sym`-1, go to IDLE and assert `done` together with that sample's `out_eop`.
    - Otherwise increment `sym_idx` and go to CP_SKIP, or stay in PASS with the counter cleared if `cp_len`=0.
- Counter comparisons are equality against (length-1), computed in CNT_WIDTH. There is no overflow path.
- `abort` has priority over all other events, including `start` and a concurrent last sample.
  - On the next enabled edge: state → IDLE, `out_valid`/`out_sop`/`out_eop` = 0, no `done`, counter and `sym_idx` = 0.
- `busy` = 1 in CP_SKIP and PASS, 0 in IDLE.

## Timing
- Reset values: `out_valid`, `out_sop`, `out_eop`, `done`, `err`, `busy` = 0. `out_data` = 0, `sym_idx` = 0. State = IDLE, counter = 0.
- Latency: exactly one enabled clock from an accepted input sample to its `out_valid`.
  - `out_data`, `out_sop`, `out_eop`, `sym_idx` and `done` are all registered with `out_valid`.
- `out_valid`, `out_sop`, `out_eop`, `done` and `err` are one-cycle pulses per event.
  - When `clk_en`=0 they hold their last value, consistent with downstream qualification by `clk_en`.
- `busy` rises one enabled cycle after `start` and falls in the same cycle `done` is asserted.
- `fft_len`=1: `out_sop` and `out_eop` are both asserted on the single sample.
- A new `start` is accepted in the cycle `done` is high. The last-sample edge has already returned the state to IDLE.
- Gaps in `in_valid` stall counting without losing framing. The output has identical gaps.
- Asserting `resetn` mid-occasion clears everything asynchronously. No `done` is produced.

## Test plan
- `cp_len`=4, `fft_len`=8, `num_sym`=2, continuous `in_valid`, data = ramp 0..23.
  - Outputs are 4..11 then 16..23.
  - `out_sop` on 4 and 16, `out_eop` on 11 and 23.
  - `sym_idx` 0 then 1. `done` with the sample 23. Each output is one cycle after its input.
- Same configuration with `in_valid` toggling 1/0 and `clk_en` low for 3 random cycles.
  - Identical output sequence and markers; only the gaps differ.
- `cp_len`=0, `fft_len`=1, `num_sym`=3, data 7,8,9.
  - Three outputs, each with `out_sop`=`out_eop`=1, `sym_idx` 0,1,2, and `done` on 9.
- `start` with `num_sym`=0: `err`=1 for one cycle, `busy` stays 0.
  - `start` again mid-occasion: `err` pulses and the output stream is unchanged.
- `abort` during PASS of symbol 1 (`cp_len`=2, `fft_len`=4, `num_sym`=3).
  - Next cycle `out_valid`=0 and `busy`=0. No `done`.
  - A following `start` restarts cleanly at `sym_idx`=0.
- `resetn` pulsed low mid-CP_SKIP: all outputs read 0 asynchronously.
  - After release, a fresh occasion produces the correct framing.
